// File: rtl/if_prefetch_buf.sv
// Instruction prefetch FIFO between fetch and IF/ID. The head entry is presented as {addr4, ins}.
// Optional same-cycle empty-buffer bypass is enabled with `IF_PREFETCH_BYPASS_EN.
module if_prefetch_buf #(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [31:0]   in_addr4,
    input  logic [31:0]   in_ins,
    output logic          in_ready,
    input  logic          flush,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [63:0]   out,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [63:0]   w_head;

    assign w_empty  = (r_count == '0);
    assign in_ready = (r_count != CW'(DEPTH));
    assign count    = r_count;
    assign w_head   = r_mem[r_rptr];

`ifdef IF_PREFETCH_BYPASS_EN
    logic w_bypass;

    // An incoming instruction is offered straight to IFID while the buffer is empty;
    // it is only stored if IFID does not take it this cycle.
    assign w_bypass  = w_empty & in_valid & ~flush;
    assign out_valid = ~w_empty | w_bypass;
    assign out       = ~w_empty ? w_head : (w_bypass ? {in_addr4, in_ins} : 64'd0);
    assign w_push    = in_valid & in_ready & ~flush & ~(w_bypass & out_ready);
    assign w_pop     = ~w_empty & out_ready & ~flush;
`else
    assign out_valid = ~w_empty;
    assign out       = out_valid ? w_head : 64'd0;
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage holds no reset; entries are only observable once count covers them.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {in_addr4, in_ins};
    end
endmodule

// File: doc/if_prefetch_buf.md
# if_prefetch_buf

Instruction prefetch buffer between the fetch stage (PC, Add4, IM) and the IF/ID pipeline register. Captures each fetched {PC+4, instruction} pair into a small FIFO so fetch can run ahead while decode is stalled. Presents the head entry to IFID in IFID's 64-bit packing. Discards all buffered wrong-path instructions on a branch/jump flush.

## Interface
- DEPTH, 4: number of entries; power of two, ≥ 2
- CW, derived $clog2(DEPTH)+1: width of `count`
- clk  input  1  clock, rising-edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  fetch presents a valid instruction this cycle
- in_addr4  input  32  PC+4 of the fetched instruction
- in_ins  input  32  fetched instruction word
- in_ready  output  1  buffer accepts a push this cycle
- flush  input  1  redirect; discard all entries and the current push
- out_ready  input  1  IFID consumes the head this cycle; low while decode stalls
- out_valid  output  1  head entry valid
- out  output  64  {addr4[31:0], ins[31:0]} of head; 0 when out_valid=0
- count  output  CW  number of stored entries

## Operation
- Circular storage of DEPTH 64-bit entries. Write pointer and read pointer are log2(DEPTH) bits and wrap modulo DEPTH. `count` is tracked separately.
- Push occurs when in_valid & in_ready & !flush. It writes {in_addr4, in_ins} at the write pointer, then increments the write pointer.
- Pop occurs when out_valid & out_ready & !flush, then increments the read pointer.
- in_ready = (count != DEPTH). It does not depend on out_ready, so there is no combinational ready path. When full, a push is refused even if a pop occurs in the same cycle.
- out_valid = (count != 0) in the base build.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- flush has priority over everything:
  - next cycle count=0 and both pointers are 0;
  - the same-cycle push is dropped;
  - the same-cycle pop is not counted as consumed.
- Entries leave in exactly the order they were pushed. Data is never modified.

## Timing
- Reset (asynchronous, immediate):
  - outputs: count=0, out_valid=0, out=0, in_ready=1;
  - pointers: 0;
  - storage contents: don't-care.
- Base latency: an entry pushed at edge N is visible on out/out_valid after edge N, so IFID can capture it at edge N+1.
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.
- Reset asserted mid-operation: buffer empties immediately, regardless of in_valid, flush or out_ready.
- Reset deassertion: in_ready=1 in the first cycle after reset is released.
- out is driven combinationally from the storage at the read pointer, gated to 0 when out_valid=0.

## Configuration
- Macro: `IF_PREFETCH_BYPASS_EN`.
- Defined:
  - when count=0, in_valid=1 and flush=0, out_valid=1 and out={in_addr4,in_ins} combinationally in the same cycle;
  - if out_ready=1 in that cycle, the entry is consumed and not stored (count stays 0);
  - if out_ready=0, the entry is stored normally;
  - adds a combinational in→out path and gives zero-cycle latency when empty.
- Undefined: no bypass; minimum latency is one cycle and out_valid depends only on count.

## Test plan
- Reset then push 3 entries with out_ready=0 (addr4=0x04,0x08,0x0C; ins=0x20080001,0x20090002,0x012A5020) -> count=3, in_ready=1, out=0x00000004_20080001.
- Push 4 entries with out_ready=0 (DEPTH=4), then hold in_valid with a 5th -> in_ready=0 and count stays 4. Raise out_ready -> pops return 0x04,0x08,0x0C,0x10 in order; the 5th entry is accepted once count<4.
- Continuous push and pop for 20 cycles with out_ready=1 -> count constant, pointers wrap past DEPTH, every addr4 emerges in sequence with no loss or duplication.
- With 3 entries stored, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out=0; the flushed-cycle push never appears.
- Assert rst asynchronously mid-cycle with count=2 -> out_valid drops to 0 and count to 0 before the next edge; after release, in_ready=1.
- Empty buffer, in_valid=1, out_ready=1:
  - with `IF_PREFETCH_BYPASS_EN` -> out_valid=1 and out={in_addr4,in_ins} in the same cycle, count stays 0;
  - without it -> out_valid=0 this cycle, then 1 with count=1 after the edge.
